// File: rtl/fp_cvt_arbiter.sv
// fp_cvt_arbiter: shares one float-to-word converter between two requesters.
// Round-robin grant, fixed settle time, optional saturation, tagged response.
//
// Ports:
//   clk, reset            clock, async active-high reset
//   req0_*, req1_*        valid/ready operand inputs (FPU issue, emulation)
//   conv_in               registered operand driving the converter
//   conv_out, conv_*flow  converter result and flags
//   rsp_*                 tagged result with valid/ready handshake
//   busy                  high whenever not idle
module fp_cvt_arbiter #(
    parameter int CONV_CYCLES = 1,
    parameter bit SATURATE    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [31:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_data,
    output logic        req1_ready,
    output logic [31:0] conv_in,
    input  logic [31:0] conv_out,
    input  logic        conv_overflow,
    input  logic        conv_underflow,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_overflow,
    output logic        rsp_underflow,
    output logic        rsp_tag,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        RESPOND
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(CONV_CYCLES - 1);

    state_t      state;
    logic        last_grant;
    logic [3:0]  cnt;
    logic        idle;
    logic        gnt0;
    logic        gnt1;
    logic [31:0] sat_data;

    assign idle = (state == IDLE);

    // Port 1 wins when alone, or when both ask and port 0 went last.
    assign gnt1 = req1_valid & (~req0_valid | ~last_grant);
    assign gnt0 = req0_valid & ~gnt1;

    assign req0_ready = idle & gnt0;
    assign req1_ready = idle & gnt1;
    assign busy       = ~idle;

    // Overflow outranks underflow if the converter ever raises both.
    always_comb begin
        sat_data = conv_out;
        if (SATURATE) begin
            if (conv_overflow)
                sat_data = 32'h7FFF_FFFF;
            else if (conv_underflow)
                sat_data = 32'h8000_0000;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            cnt           <= 4'd0;
            conv_in       <= 32'd0;
            rsp_valid     <= 1'b0;
            rsp_data      <= 32'd0;
            rsp_overflow  <= 1'b0;
            rsp_underflow <= 1'b0;
            rsp_tag       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req0_ready | req1_ready) begin
                        conv_in    <= req1_ready ? req1_data : req0_data;
                        rsp_tag    <= req1_ready;
                        last_grant <= req1_ready;
                        cnt        <= CNT_INIT;
                        state      <= CONVERT;
                    end
                end
                CONVERT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rsp_data      <= sat_data;
                        rsp_overflow  <= conv_overflow;
                        rsp_underflow <= conv_underflow;
                        rsp_valid     <= 1'b1;
                        state         <= RESPOND;
                    end
                end
                RESPOND: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_cvt_arbiter.sv
// tb_fp_cvt_arbiter: two instances (1-cycle saturating, 4-cycle raw),
// each fed by a behavioural float-to-int converter stub.
module tb_fp_cvt_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        r0v [2];
    logic        r1v [2];
    logic        rr  [2];
    logic        fb  [2];
    logic [31:0] r0d [2];
    logic [31:0] r1d [2];
    logic [31:0] cin [2];
    logic [31:0] cout[2];
    logic [33:0] cr  [2];
    logic        r0r [2];
    logic        r1r [2];
    logic        covf[2];
    logic        cunf[2];
    logic        rv  [2];
    logic [31:0] rd  [2];
    logic        rovf[2];
    logic        runf[2];
    logic        rtag[2];
    logic        bsy [2];

    int cyc  = 0;
    int nchk = 0;
    int nerr = 0;
    bit lastg[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Truncating float -> int32; returns {ovf, unf, value}.
    function automatic logic [33:0] fcvt(input logic [31:0] f);
        logic        s;
        int          ex;
        logic [63:0] mag;
        logic [31:0] v;
        s = f[31];
        if (f[30:23] == 8'hFF) begin
            if (f[22:0] != 23'd0 || !s) return {2'b10, 32'h5A5A5A5A};
            return {2'b01, 32'h5A5A5A5A};
        end
        if (f[30:23] < 8'd127) return 34'd0;
        ex = int'(f[30:23]) - 127;
        if (ex > 31)
            return s ? {2'b01, 32'h5A5A5A5A} : {2'b10, 32'h5A5A5A5A};
        mag = {40'd0, 1'b1, f[22:0]};
        if (ex >= 23) mag = mag << (ex - 23);
        else mag = mag >> (23 - ex);
        if (!s) begin
            if (mag > 64'h7FFF_FFFF) return {2'b10, 32'h5A5A5A5A};
            return {2'b00, mag[31:0]};
        end
        if (mag > 64'h8000_0000) return {2'b01, 32'h5A5A5A5A};
        v = 32'd0 - mag[31:0];
        return {2'b00, v};
    endfunction

    // Instance 0 saturates, instance 1 passes the raw result.
    function automatic logic [33:0] model(input int d, input logic [31:0] op);
        logic [33:0] r;
        r = fcvt(op);
        if (d == 0) begin
            if (r[33]) r[31:0] = 32'h7FFF_FFFF;
            else if (r[32]) r[31:0] = 32'h8000_0000;
        end
        return r;
    endfunction

    function automatic int cc(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [31:0] sp[10] = '{32'h0, 32'h8000_0000, 32'h7F80_0000,
                               32'hFF80_0000, 32'h7FC0_0000, 32'h4F00_0000,
                               32'hCF00_0000, 32'h4EFF_FFFF, 32'h3F00_0000,
                               32'hBF7F_FFFF};
        case ($urandom_range(0, 3))
            0: return {1'($urandom_range(0, 1)), 8'($urandom_range(110, 165)),
                       23'($urandom)};
            1: return sp[$urandom_range(0, 9)];
            2: return $urandom;
            default: return {1'($urandom_range(0, 1)),
                             8'($urandom_range(127, 157)), 23'($urandom)};
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_cv
        assign cr[g]   = fcvt(cin[g]);
        assign cout[g] = cr[g][31:0];
        assign covf[g] = cr[g][33] | fb[g];
        assign cunf[g] = cr[g][32] | fb[g];
    end

    fp_cvt_arbiter #(.CONV_CYCLES(1), .SATURATE(1)) u0 (
        .clk(clk), .reset(reset),
        .req0_valid(r0v[0]), .req0_data(r0d[0]), .req0_ready(r0r[0]),
        .req1_valid(r1v[0]), .req1_data(r1d[0]), .req1_ready(r1r[0]),
        .conv_in(cin[0]), .conv_out(cout[0]),
        .conv_overflow(covf[0]), .conv_underflow(cunf[0]),
        .rsp_valid(rv[0]), .rsp_ready(rr[0]), .rsp_data(rd[0]),
        .rsp_overflow(rovf[0]), .rsp_underflow(runf[0]),
        .rsp_tag(rtag[0]), .busy(bsy[0])
    );

    fp_cvt_arbiter #(.CONV_CYCLES(4), .SATURATE(0)) u1 (
        .clk(clk), .reset(reset),
        .req0_valid(r0v[1]), .req0_data(r0d[1]), .req0_ready(r0r[1]),
        .req1_valid(r1v[1]), .req1_data(r1d[1]), .req1_ready(r1r[1]),
        .conv_in(cin[1]), .conv_out(cout[1]),
        .conv_overflow(covf[1]), .conv_underflow(cunf[1]),
        .rsp_valid(rv[1]), .rsp_ready(rr[1]), .rsp_data(rd[1]),
        .rsp_overflow(rovf[1]), .rsp_underflow(runf[1]),
        .rsp_tag(rtag[1]), .busy(bsy[1])
    );

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Present one operand and return just after its accepting edge.
    task automatic send(input int d, input bit p, input logic [31:0] op,
                        output int acc, output bit tmo);
        @(negedge clk);
        if (p) begin r1v[d] = 1'b1; r1d[d] = op; end
        else begin r0v[d] = 1'b1; r0d[d] = op; end
        tmo = 1'b1;
        for (int i = 0; i < 60; i++) begin
            #1;
            if ((p ? r1r[d] : r0r[d]) === 1'b1) begin tmo = 1'b0; break; end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        acc = cyc;
        if (p) r1v[d] = 1'b0;
        else r0v[d] = 1'b0;
    endtask

    task automatic recv(input int d, output int vc, output bit tmo);
        tmo = 1'b1;
        vc  = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (rv[d] === 1'b1) begin tmo = 1'b0; vc = cyc; break; end
        end
    endtask

    task automatic ack(input int d);
        rr[d] = 1'b1;
        @(posedge clk);
        #1;
        rr[d] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        for (int d = 0; d < 2; d++) begin
            nchk++; if (bsy[d] !== 1'b0) begin nerr++;
                $display("FAIL rst_busy[%0d]: got %b exp 0", d, bsy[d]); end
            nchk++; if (rv[d] !== 1'b0) begin nerr++;
                $display("FAIL rst_valid[%0d]: got %b exp 0", d, rv[d]); end
            nchk++; if (cin[d] !== 32'd0) begin nerr++;
                $display("FAIL rst_conv_in[%0d]: got %h exp 0", d, cin[d]); end
            nchk++; if (rd[d] !== 32'd0) begin nerr++;
                $display("FAIL rst_data[%0d]: got %h exp 0", d, rd[d]); end
            nchk++; if ({rovf[d], runf[d], rtag[d]} !== 3'b000) begin nerr++;
                $display("FAIL rst_flags_tag[%0d]: got %b exp 000", d,
                         {rovf[d], runf[d], rtag[d]}); end
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        nchk++; if (bsy[0] !== 1'b0 || rv[0] !== 1'b0) begin nerr++;
            $display("FAIL rst_idle: busy %b valid %b exp 0 0", bsy[0], rv[0]); end
    endtask

    task automatic test_directed();
        logic [31:0] ops[4] = '{32'h40490FDB, 32'hC0400000,
                               32'h7F800000, 32'hFF800000};
        bit          ps[4]  = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] ed[4]  = '{32'h3, 32'hFFFFFFFD,
                               32'h7FFFFFFF, 32'h80000000};
        logic [1:0]  ef[4]  = '{2'b00, 2'b00, 2'b10, 2'b01};
        int acc, vc;
        bit tmo;
        for (int k = 0; k < 4; k++) begin
            send(0, ps[k], ops[k], acc, tmo);
            nchk++; if (tmo) begin nerr++;
                $display("FAIL dir_grant_timeout[%0d]: got none exp ready", k); end
            recv(0, vc, tmo);
            nchk++; if (tmo) begin nerr++;
                $display("FAIL dir_rsp_timeout[%0d]: got none exp valid", k); end
            nchk++; if (vc - acc != 1) begin nerr++;
                $display("FAIL dir_latency[%0d]: got %0d exp 1", k, vc - acc); end
            nchk++; if (rd[0] !== ed[k]) begin nerr++;
                $display("FAIL dir_data[%0d]: got %h exp %h", k, rd[0], ed[k]); end
            nchk++; if ({rovf[0], runf[0]} !== ef[k]) begin nerr++;
                $display("FAIL dir_flags[%0d]: got %b exp %b", k,
                         {rovf[0], runf[0]}, ef[k]); end
            nchk++; if (rtag[0] !== ps[k]) begin nerr++;
                $display("FAIL dir_tag[%0d]: got %b exp %b", k, rtag[0], ps[k]); end
            nchk++; if (cin[0] !== ops[k]) begin nerr++;
                $display("FAIL dir_conv_in[%0d]: got %h exp %h", k, cin[0], ops[k]); end
            ack(0);
            nchk++; if (rv[0] !== 1'b0) begin nerr++;
                $display("FAIL dir_drop[%0d]: got %b exp 0", k, rv[0]); end
        end
    endtask

    task automatic test_nosat();
        logic [31:0] ops[3] = '{32'h7F800000, 32'hFF800000, 32'h40490FDB};
        logic [31:0] ed[3]  = '{32'h5A5A5A5A, 32'h5A5A5A5A, 32'h3};
        logic [1:0]  ef[3]  = '{2'b10, 2'b01, 2'b00};
        int acc, vc;
        bit tmo;
        for (int k = 0; k < 3; k++) begin
            send(1, 1'b0, ops[k], acc, tmo);
            recv(1, vc, tmo);
            nchk++; if (tmo || vc - acc != 4) begin nerr++;
                $display("FAIL raw_latency[%0d]: got %0d exp 4", k, vc - acc); end
            nchk++; if (rd[1] !== ed[k]) begin nerr++;
                $display("FAIL raw_data[%0d]: got %h exp %h", k, rd[1], ed[k]); end
            nchk++; if ({rovf[1], runf[1]} !== ef[k]) begin nerr++;
                $display("FAIL raw_flags[%0d]: got %b exp %b", k,
                         {rovf[1], runf[1]}, ef[k]); end
            ack(1);
        end
    endtask

    task automatic test_round_robin();
        int n = 0;
        int prev = -1;
        int both = 0;
        pulse_reset();
        @(negedge clk);
        r0d[0] = 32'h3F800000;
        r1d[0] = 32'h40000000;
        r0v[0] = 1'b1;
        r1v[0] = 1'b1;
        rr[0]  = 1'b1;
        for (int i = 0; i < 100 && n < 4; i++) begin
            #1;
            if (r0r[0] && r1r[0]) both++;
            if (rv[0]) begin
                nchk++; if (rtag[0] !== n[0]) begin nerr++;
                    $display("FAIL rr_tag[%0d]: got %b exp %b", n, rtag[0], n[0]); end
                nchk++; if (rd[0] !== (n[0] ? 32'd2 : 32'd1)) begin nerr++;
                    $display("FAIL rr_data[%0d]: got %h exp %h", n, rd[0],
                             n[0] ? 32'd2 : 32'd1); end
                if (prev >= 0) begin
                    nchk++; if (cyc - prev != 3) begin nerr++;
                        $display("FAIL rr_spacing[%0d]: got %0d exp 3", n,
                                 cyc - prev); end
                end
                prev = cyc;
                n++;
                if (n == 4) begin r0v[0] = 1'b0; r1v[0] = 1'b0; end
            end
            @(negedge clk);
        end
        nchk++; if (n != 4) begin nerr++;
            $display("FAIL rr_count: got %0d exp 4", n); end
        nchk++; if (both != 0) begin nerr++;
            $display("FAIL rr_two_ready: got %0d exp 0", both); end
        @(posedge clk);
        #1;
        rr[0] = 1'b0;
    endtask

    task automatic test_hold();
        int acc, vc, bad;
        bit tmo;
        logic [31:0] sd;
        pulse_reset();
        send(1, 1'b1, 32'h42280000, acc, tmo);
        r0d[1] = 32'h3F800000;
        r0v[1] = 1'b1;
        bad = 0;
        tmo = 1'b1;
        vc = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (r0r[1] | r1r[1]) bad++;
            if (rv[1] === 1'b1) begin tmo = 1'b0; vc = cyc; break; end
        end
        nchk++; if (tmo || vc - acc != 4) begin nerr++;
            $display("FAIL hold_latency: got %0d exp 4", vc - acc); end
        nchk++; if (rd[1] !== 32'h2A || rtag[1] !== 1'b1) begin nerr++;
            $display("FAIL hold_rsp: got %h/%b exp 0000002a/1", rd[1], rtag[1]); end
        sd = rd[1];
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rd[1] !== sd || rtag[1] !== 1'b1 || rv[1] !== 1'b1) bad++;
            if (rovf[1] | runf[1] | r0r[1] | r1r[1]) bad++;
        end
        nchk++; if (bad != 0) begin nerr++;
            $display("FAIL hold_stable: got %0d glitches exp 0", bad); end
        rr[1] = 1'b1;
        #1;
        nchk++; if (r0r[1] !== 1'b0) begin nerr++;
            $display("FAIL hold_early_ready: got %b exp 0", r0r[1]); end
        @(posedge clk);
        #1;
        rr[1] = 1'b0;
        @(negedge clk);
        nchk++; if (rv[1] !== 1'b0 || r0r[1] !== 1'b1) begin nerr++;
            $display("FAIL hold_after: got valid %b ready %b exp 0 1",
                     rv[1], r0r[1]); end
        @(posedge clk);
        #1;
        acc = cyc;
        r0v[1] = 1'b0;
        recv(1, vc, tmo);
        nchk++; if (tmo || rd[1] !== 32'd1 || rtag[1] !== 1'b0) begin nerr++;
            $display("FAIL hold_next: got %h/%b exp 00000001/0", rd[1], rtag[1]); end
        ack(1);
    endtask

    task automatic test_reset_mid();
        int acc, vc, bad;
        bit tmo;
        send(1, 1'b0, 32'h40A00000, acc, tmo);
        @(negedge clk);
        nchk++; if (bsy[1] !== 1'b1) begin nerr++;
            $display("FAIL mid_busy: got %b exp 1", bsy[1]); end
        reset = 1'b1;
        #1;
        nchk++; if (bsy[1] !== 1'b0 || cin[1] !== 32'd0 || rv[1] !== 1'b0)
        begin nerr++;
            $display("FAIL mid_async: got busy %b conv_in %h valid %b exp 0 0 0",
                     bsy[1], cin[1], rv[1]); end
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (rv[0] | rv[1]) bad++;
        end
        nchk++; if (bad != 0) begin nerr++;
            $display("FAIL mid_no_rsp: got %0d exp 0", bad); end
        r0d[1] = 32'h40A00000;
        r1d[1] = 32'h3F800000;
        r0v[1] = 1'b1;
        r1v[1] = 1'b1;
        #1;
        nchk++; if (r0r[1] !== 1'b1 || r1r[1] !== 1'b0) begin nerr++;
            $display("FAIL mid_first_grant: got %b%b exp 10", r0r[1], r1r[1]); end
        r1v[1] = 1'b0;
        @(posedge clk);
        #1;
        acc = cyc;
        r0v[1] = 1'b0;
        recv(1, vc, tmo);
        nchk++; if (tmo || vc - acc != 4 || rd[1] !== 32'd5 || rtag[1] !== 1'b0)
        begin nerr++;
            $display("FAIL mid_resume: got %h/%b lat %0d exp 00000005/0 lat 4",
                     rd[1], rtag[1], vc - acc); end
        ack(1);
    endtask

    task automatic test_both_flags();
        int acc, vc;
        bit tmo;
        logic [31:0] ed;
        for (int d = 0; d < 2; d++) begin
            fb[d] = 1'b1;
            send(d, 1'b1, 32'h3F800000, acc, tmo);
            recv(d, vc, tmo);
            ed = (d == 0) ? 32'h7FFFFFFF : 32'h1;
            nchk++; if (tmo || rd[d] !== ed) begin nerr++;
                $display("FAIL both_data[%0d]: got %h exp %h", d, rd[d], ed); end
            nchk++; if ({rovf[d], runf[d]} !== 2'b11) begin nerr++;
                $display("FAIL both_flags[%0d]: got %b exp 11", d,
                         {rovf[d], runf[d]}); end
            ack(d);
            fb[d] = 1'b0;
        end
    endtask

    task automatic test_random();
        logic [31:0] ops[2];
        logic [33:0] e;
        int pv, rem, served, ep, gp, acc, vc, h, bad;
        bit tmo;
        pulse_reset();
        lastg[0] = 1'b1;
        lastg[1] = 1'b1;
        for (int d = 0; d < 2; d++) begin
            for (int it = 0; it < 30; it++) begin
                pv = $urandom_range(1, 3);
                ops[0] = rnd_op();
                ops[1] = rnd_op();
                @(negedge clk);
                r0d[d] = ops[0];
                r1d[d] = ops[1];
                r0v[d] = pv[0];
                r1v[d] = pv[1];
                served = 0;
                while (served != pv) begin
                    rem = pv & ~served;
                    if (rem == 3) ep = lastg[d] ? 0 : 1;
                    else ep = (rem == 2) ? 1 : 0;
                    tmo = 1'b1;
                    for (int i = 0; i < 60; i++) begin
                        #1;
                        if (r0r[d] | r1r[d]) begin tmo = 1'b0; break; end
                        @(negedge clk);
                    end
                    nchk++; if (tmo) begin nerr++;
                        $display("FAIL rnd_grant_timeout[%0d]: got none exp ready", d);
                        r0v[d] = 1'b0; r1v[d] = 1'b0;
                        break;
                    end
                    gp = r1r[d] ? 1 : 0;
                    nchk++; if ((r0r[d] & r1r[d]) || gp != ep) begin nerr++;
                        $display("FAIL rnd_grant[%0d]: got %b%b exp port %0d",
                                 d, r1r[d], r0r[d], ep); end
                    @(posedge clk);
                    #1;
                    acc = cyc;
                    if (gp == 1) r1v[d] = 1'b0;
                    else r0v[d] = 1'b0;
                    rr[d] = 1'($urandom_range(0, 1));
                    recv(d, vc, tmo);
                    e = model(d, ops[gp]);
                    nchk++; if (tmo || vc - acc != cc(d)) begin nerr++;
                        $display("FAIL rnd_latency[%0d]: got %0d exp %0d",
                                 d, vc - acc, cc(d)); end
                    nchk++; if (rd[d] !== e[31:0]) begin nerr++;
                        $display("FAIL rnd_data[%0d] op %h: got %h exp %h",
                                 d, ops[gp], rd[d], e[31:0]); end
                    nchk++; if ({rovf[d], runf[d]} !== e[33:32]) begin nerr++;
                        $display("FAIL rnd_flags[%0d] op %h: got %b exp %b",
                                 d, ops[gp], {rovf[d], runf[d]}, e[33:32]); end
                    nchk++; if (rtag[d] !== gp[0]) begin nerr++;
                        $display("FAIL rnd_tag[%0d]: got %b exp %b",
                                 d, rtag[d], gp[0]); end
                    if (rr[d]) begin
                        @(posedge clk);
                        #1;
                        rr[d] = 1'b0;
                    end else begin
                        h = $urandom_range(0, 3);
                        bad = 0;
                        repeat (h) begin
                            @(negedge clk);
                            if (rd[d] !== e[31:0] || rv[d] !== 1'b1) bad++;
                            if (r0r[d] | r1r[d]) bad++;
                        end
                        nchk++; if (bad != 0) begin nerr++;
                            $display("FAIL rnd_hold[%0d]: got %0d glitches exp 0",
                                     d, bad); end
                        ack(d);
                    end
                    nchk++; if (rv[d] !== 1'b0) begin nerr++;
                        $display("FAIL rnd_drop[%0d]: got %b exp 0", d, rv[d]); end
                    lastg[d] = gp[0];
                    served |= (1 << gp);
                end
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            r0v[d] = 1'b0; r1v[d] = 1'b0; rr[d] = 1'b0; fb[d] = 1'b0;
            r0d[d] = 32'd0; r1d[d] = 32'd0;
        end
        reset = 1'b1;
        test_reset();
        test_directed();
        test_nosat();
        test_round_robin();
        test_hold();
        test_reset_mid();
        test_both_flags();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish exp finish");
        $fatal(1);
    end

endmodule

// File: doc/fp_cvt_arbiter.md
Name: fp_cvt_arbiter

Overview:
- Sequencer and arbiter that shares one float-to-word converter (IEEE-754 single to signed 32-bit, truncating, with overflow/underflow flags) between two requesters: the FPU issue stage (port 0) and the exception/emulation path (port 1).
- Latches the operand into a stable register that drives the converter, waits a fixed settle time, and captures the result and flags.
- Applies optional saturation, then returns the result with a requester tag over a valid/ready handshake.
- Sits between the FPU decode logic and the converter instance in the coprocessor-1 datapath.

Parameters:
- CONV_CYCLES, 1: cycles the converter input is held before the result is sampled (1..15).
- SATURATE, 1: 1 = replace result on overflow with 32'h7FFFFFFF and on underflow with 32'h80000000; 0 = pass the converter result through unchanged.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- req0_valid  input  1  requester 0 has an operand
- req0_data  input  32  requester 0 single-precision operand
- req0_ready  output  1  requester 0 operand accepted this cycle
- req1_valid  input  1  requester 1 has an operand
- req1_data  input  32  requester 1 operand
- req1_ready  output  1  requester 1 operand accepted this cycle
- conv_in  output  32  operand register driving the converter
- conv_out  input  32  converter integer result
- conv_overflow  input  1  converter overflow flag
- conv_underflow  input  1  converter underflow flag
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer accepts result
- rsp_data  output  32  integer result
- rsp_overflow  output  1  overflow flag
- rsp_underflow  output  1  underflow flag
- rsp_tag  output  1  index of the requester that owns the result
- busy  output  1  state is not IDLE

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high (ports clk, reset).
- Reset values:
  - state = IDLE, last_grant = 1 (so port 0 wins first).
  - conv_in, rsp_data, rsp_overflow, rsp_underflow, rsp_tag, settle counter = 0.
  - rsp_valid = 0, busy = 0.
- State machine has three states: IDLE, CONVERT, RESPOND.
- IDLE:
  - Grant is combinational.
  - Only one valid: that port is granted.
  - Both valid: grant the port not equal to last_grant (round-robin).
  - reqN_ready = (state==IDLE) & granted & reqN_valid. At most one ready is high per cycle.
  - On the accepting edge: conv_in <= reqN_data, rsp_tag <= N, last_grant <= N, counter <= CONV_CYCLES-1, go to CONVERT.
- CONVERT:
  - conv_in is held constant.
  - If counter != 0, decrement.
  - If counter == 0, sample the converter and go to RESPOND:
    - rsp_overflow <= conv_overflow, rsp_underflow <= conv_underflow.
    - rsp_data <= SATURATE ? (ovf ? 7FFFFFFF : unf ? 80000000 : conv_out) : conv_out.
  - rsp_valid <= 1 on the same edge.
- RESPOND:
  - rsp_* are held stable while rsp_valid=1 & rsp_ready=0, for an unbounded time.
  - On the edge where rsp_valid & rsp_ready: rsp_valid <= 0, go to IDLE.
  - No overlap: a new request is accepted no earlier than the cycle after the response handshake.
- Latency: accept at edge N, rsp_valid high after edge N+CONV_CYCLES. Best-case throughput is one result per CONV_CYCLES+2 cycles.
- Requests are ignored outside IDLE: readies stay low and requester data is not sampled. Requesters must hold valid and data until ready.
- A valid request that loses arbitration stays pending. It wins the next IDLE arbitration, because last_grant now points at the other port.
- rsp_ready asserted while rsp_valid=0 has no effect.
- conv_in retains its last operand in IDLE and RESPOND; the converter output is don't-care outside the CONVERT sample edge.
- Reset asserted mid-CONVERT or mid-RESPOND: the in-flight result is discarded, all outputs return to reset values immediately (asynchronously), and no response is produced.
- Flags are mutually exclusive by converter contract. If both are seen, overflow takes priority for saturation; both flags are still reported.

Test Plan:
- Port 0 sends 32'h40490FDB (3.14159), CONV_CYCLES=1, rsp_ready=1 -> req0_ready high 1 cycle; 1 cycle later rsp_valid with rsp_data=32'h00000003, rsp_tag=0, flags 0.
- Port 1 sends 32'hC0400000 (-3.0) -> rsp_data=32'hFFFFFFFD, rsp_tag=1.
- Port 0 sends 32'h7F800000 (+inf): SATURATE=1 -> rsp_data=32'h7FFFFFFF, rsp_overflow=1. Port 0 sends 32'hFF800000 (-inf) -> rsp_data=32'h80000000, rsp_underflow=1. With SATURATE=0 -> rsp_data equals conv_out and flags still set.
- Both ports valid continuously from reset, operands 32'h3F800000 and 32'h40000000 -> results alternate tag 0 (value 1), 1 (value 2), 0, 1; never two consecutive grants to one port.
- CONV_CYCLES=4, rsp_ready held low 5 cycles after rsp_valid -> rsp_valid high after edge N+4; rsp_* stable for all 5 cycles; both readies low until the cycle after the handshake.
- Reset pulsed during CONVERT -> rsp_valid stays 0; busy=0 and conv_in=0 immediately; next request proceeds normally and is granted to port 0.
